// File: rtl/argo_chan_pkg.sv
// argo_chan_pkg: shared sizing helpers for Argo channel buffers.
package argo_chan_pkg;
    localparam int PREFETCH_DEPTH = 2;

    function automatic int chan_cap(input int aw);
        return (1 << aw) + PREFETCH_DEPTH;
    endfunction

    function automatic int chan_cnt_w(input int aw);
        return aw + 2;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/argo_chan_prefetch.sv
// argo_chan_prefetch: 2-entry skid stage (head + spare) feeding the FWFT output.
module argo_chan_prefetch #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ret_valid,
    input  logic [DW-1:0] ret_data,
    input  logic          pop,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occ
);
    logic          head_v_q, head_v_d, spare_v_q, spare_v_d;
    logic [DW-1:0] head_q, head_d, spare_q, spare_d;

    always_comb begin
        head_v_d  = head_v_q;
        head_d    = head_q;
        spare_v_d = spare_v_q;
        spare_d   = spare_q;
        if (pop && spare_v_q) begin
            head_d    = spare_q;
            spare_v_d = ret_valid;
            spare_d   = ret_valid ? ret_data : spare_q;
        end else if (pop) begin
            head_v_d = ret_valid;
            head_d   = ret_valid ? ret_data : '0;
        end else if (ret_valid && !head_v_q) begin
            head_v_d = 1'b1;
            head_d   = ret_data;
        end else if (ret_valid) begin
            spare_v_d = 1'b1;
            spare_d   = ret_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_v_q  <= 1'b0;
            head_q    <= '0;
            spare_v_q <= 1'b0;
            spare_q   <= '0;
        end else begin
            head_v_q  <= head_v_d;
            head_q    <= head_d;
            spare_v_q <= spare_v_d;
            spare_q   <= spare_d;
        end
    end

    assign out_valid = head_v_q;
    assign out_data  = head_q;
    assign occ       = {1'b0, head_v_q} + {1'b0, spare_v_q};
endmodule

// File: rtl/argo_dp_ram.sv
// argo_dp_ram: simple dual-port block RAM, registered read, contents not reset.
module argo_dp_ram #(
    parameter int AW = 3,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/argo_chan_fifo.sv
// argo_chan_fifo: RAM-backed valid/ready channel FIFO with FWFT prefetch output.
module argo_chan_fifo
    import argo_chan_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  empty,
    output logic                  full
);
    localparam logic [ADDR_WIDTH:0] RAM_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic [ADDR_WIDTH+1:0] count_q, count_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  push, pop, issue;
    logic [1:0]            occ;
    logic [2:0]            load;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // A pop this cycle frees a prefetch slot in time for a read issued now.
    always_comb begin
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        load      = {1'b0, occ} + {2'b0, rd_pend_q} - {2'b0, pop};
        issue     = (ram_cnt_q != '0) && (load < 3'(PREFETCH_DEPTH));
        wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(push);
        rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(issue);
        ram_cnt_d = ram_cnt_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
        count_d   = count_q + (ADDR_WIDTH+2)'(push) - (ADDR_WIDTH+2)'(pop);
        rd_pend_d = issue;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            count_q   <= count_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    argo_dp_ram #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    argo_chan_prefetch #(.DW(DATA_WIDTH)) u_pf (
        .clk       (clk),
        .rst_n     (rst_n),
        .ret_valid (rd_pend_q),
        .ret_data  (ram_rdata),
        .pop       (pop),
        .out_valid (out_valid),
        .out_data  (out_data),
        .occ       (occ)
    );

    assign in_ready = (ram_cnt_q != RAM_FULL);
    assign full     = !in_ready;
    assign count    = count_q;
    assign empty    = (count_q == '0);
endmodule

// File: tb/tb_argo_chan_fifo.sv
// tb_argo_chan_fifo: directed checks of argo_chan_fifo with a reference order queue.
module tb_argo_chan_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic [4:0]  count;
    logic        empty;
    logic        full;

    int total = 0;
    int bad = 0;
    int npush = 0;
    int npop = 0;
    logic [31:0] q[$];

    argo_chan_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: record the transfers the edge will perform, then settle.
    task automatic cyc();
        logic do_push, do_pop;
        do_push = in_valid && in_ready;
        do_pop  = out_valid && out_ready;
        if (do_pop) begin
            if (q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
            else chk("pop_data", out_data, q.pop_front());
            npop++;
        end
        if (do_push) begin
            q.push_back(in_data);
            npush++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single element latency
        in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("single_cnt1", {27'd0, count}, 32'd1);
        chk("single_ov_t0", {31'd0, out_valid}, 32'd0);
        cyc();
        chk("single_ov_t1", {31'd0, out_valid}, 32'd0);
        cyc();
        chk("single_ov_t2", {31'd0, out_valid}, 32'd1);
        chk("single_data", out_data, 32'hA5A5_0001);
        cyc();
        chk("single_cnt0", {27'd0, count}, 32'd0);
        chk("single_empty", {31'd0, empty}, 32'd1);
        chk("single_ov_gone", {31'd0, out_valid}, 32'd0);

        // fill with consumer stalled
        out_ready = 1'b0;
        npush = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_data = i;
            cyc();
        end
        in_valid = 1'b0;
        cyc(); cyc();
        chk("fill_accepted", npush, 32'd10);
        chk("fill_count", {27'd0, count}, 32'd10);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fill_out_valid", {31'd0, out_valid}, 32'd1);
        chk("fill_out_data", out_data, 32'd0);

        // push blocked while full, pop proceeds
        in_valid = 1'b1; in_data = 32'd99; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("fullpp_count", {27'd0, count}, 32'd9);
        chk("fullpp_in_ready", {31'd0, in_ready}, 32'd1);
        chk("fullpp_head", out_data, 32'd1);
        npop = 0;
        for (int k = 0; k < 30 && out_valid; k++) cyc();
        chk("drain_pops", npop, 32'd9);
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_q", q.size(), 32'd0);

        // streaming
        out_ready = 1'b1; npop = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 32'h1000 + i;
            cyc();
            if (i >= 2) chk("stream_no_bubble", {31'd0, out_valid}, 32'd1);
            chk("stream_cnt_le3", {31'd0, count <= 5'd3}, 32'd1);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !empty; k++) cyc();
        chk("stream_pops", npop, 32'd100);
        chk("stream_empty", {31'd0, empty}, 32'd1);

        // wrap-around with random consumer gaps
        for (int r = 0; r < 3; r++) begin
            out_ready = 1'b0; npop = 0;
            for (int i = 0; i < 8; i++) begin
                in_valid = 1'b1; in_data = 32'h2000 + r * 16 + i;
                cyc();
            end
            in_valid = 1'b0;
            for (int k = 0; k < 200 && npop < 8; k++) begin
                out_ready = 1'($urandom_range(0, 1));
                cyc();
            end
            chk("wrap_pops", npop, 32'd8);
            chk("wrap_q", q.size(), 32'd0);
            out_ready = 1'b0;
            cyc();
            chk("wrap_empty", {31'd0, empty}, 32'd1);
        end

        // async reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 32'h3000 + i;
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        chk("prerst_count", {27'd0, count}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_count", {27'd0, count}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1; npop = 0;
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && npop < 1; k++) cyc();
        chk("post_rst_pops", npop, 32'd1);
        chk("post_rst_empty", {31'd0, empty}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
